reg_pair_seq: RTL

REG_PAIR_SEQ -- requirements
Module: reg_pair_seq

---
 rtl/reg_pair_seq_if.sv | 26 ++
 rtl/reg_pair_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reg_pair_seq_if.sv
// Command and register-bank signals of the 16-bit register-pair sequencer.
// The slave side is the sequencer. The master side is whoever issues commands and owns the bank.
interface reg_pair_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_pair;
    logic [15:0] cmd_data;
    logic [2:0]  bank_reg;
    logic [7:0]  bank_wdata;
    logic        bank_we;
    logic [15:0] bank_rdata16;
    logic        busy;
    logic        done;
    logic [15:0] result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_pair, cmd_data, bank_rdata16,
        output cmd_ready, bank_reg, bank_wdata, bank_we, busy, done, result
    );

    modport master (
        output cmd_valid, cmd_op, cmd_pair, cmd_data, bank_rdata16,
        input  cmd_ready, bank_reg, bank_wdata, bank_we, busy, done, result
    );
endinterface

// File: rtl/reg_pair_seq.sv
// Register-pair sequencer. It runs LOAD16/INC16/DEC16/WRITE8 commands against an 8-byte bank.
// 16-bit operations write the low byte (index 2p+1) first and the high byte (index 2p) second.
module reg_pair_seq (
    input  logic          clk,
    input  logic          reset,
    reg_pair_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_LO,
        S_WR_HI,
        S_WR_B,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD16 = 2'b00;
    localparam logic [1:0] OP_INC16  = 2'b01;
    localparam logic [1:0] OP_DEC16  = 2'b10;
    localparam logic [1:0] OP_WRITE8 = 2'b11;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [1:0]  r_pair;
    logic [7:0]  r_byte;
    logic        r_sel;
    logic [15:0] r_value;
    logic [15:0] r_result;
    logic        w_accept;

    assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_LOAD16: w_next = S_WR_LO;
                        OP_INC16:  w_next = S_READ;
                        OP_DEC16:  w_next = S_READ;
                        default:   w_next = S_WR_B;
                    endcase
                end
            end
            S_READ:  w_next = S_WR_LO;
            S_WR_LO: w_next = S_WR_HI;
            S_WR_HI: w_next = S_DONE;
            S_WR_B:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The result is loaded on the edge that enters DONE, so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op     <= OP_LOAD16;
            r_pair   <= 2'd0;
            r_byte   <= 8'h00;
            r_sel    <= 1'b0;
            r_value  <= 16'h0000;
            r_result <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_op    <= bus.cmd_op;
                r_pair  <= bus.cmd_pair;
                r_byte  <= bus.cmd_data[7:0];
                r_sel   <= bus.cmd_data[8];
                r_value <= bus.cmd_data;
            end
            if (r_state == S_READ) begin
                r_value <= (r_op == OP_INC16) ? (bus.bank_rdata16 + 16'd1)
                                              : (bus.bank_rdata16 - 16'd1);
            end
            if (r_state == S_WR_HI) begin
                r_result <= r_value;
            end
            if (r_state == S_WR_B) begin
                r_result <= {8'h00, r_byte};
            end
        end
    end

    always_comb begin
        bus.cmd_ready  = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        bus.bank_reg   = 3'd0;
        bus.bank_wdata = 8'h00;
        bus.bank_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            S_READ: begin
                bus.bank_reg = {r_pair, 1'b0};
            end
            S_WR_LO: begin
                bus.bank_reg   = {r_pair, 1'b1};
                bus.bank_wdata = r_value[7:0];
                bus.bank_we    = 1'b1;
            end
            S_WR_HI: begin
                bus.bank_reg   = {r_pair, 1'b0};
                bus.bank_wdata = r_value[15:8];
                bus.bank_we    = 1'b1;
            end
            S_WR_B: begin
                bus.bank_reg   = {r_pair, r_sel};
                bus.bank_wdata = r_byte;
                bus.bank_we    = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

    assign bus.result = r_result;
endmodule
